// File: rtl/ddr_rd_data_check.sv
// Checks one monitored DDR read burst against an incrementing expected pattern,
// flagging byte-masked data mismatches, bad responses and rlast/length disagreements.
module ddr_rd_data_check (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ddr_ready,
  input  logic         arvalid,
  input  logic         arready,
  input  logic [7:0]   arlen,
  input  logic [127:0] rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  input  logic [127:0] exp_data,
  input  logic [15:0]  exp_strb,
  input  logic         clr,
  output logic         done,
  output logic         pass,
  output logic         fail,
  output logic         proto_err,
  output logic [7:0]   err_cnt,
  output logic [8:0]   beat_cnt
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t       state_q, state_d;
  logic [7:0]   len_q, len_d;
  logic         rready_q, rready_d;
  logic         fail_q, fail_d;
  logic         proto_q, proto_d;
  logic [7:0]   err_q, err_d;
  logic [8:0]   beat_q, beat_d;

  logic [127:0] exp_beat;
  logic [127:0] bmask;
  logic         beat_acc;
  logic         beat_bad;
  logic         at_len;

  // Beat k expects the low word of exp_data advanced by k (wrapping); upper bits fixed.
  always_comb begin
    exp_beat = {exp_data[127:32], exp_data[31:0] + {23'd0, beat_q}};
    bmask    = '0;
    for (int i = 0; i < 16; i++) bmask[8*i +: 8] = {8{exp_strb[i]}};
    beat_bad = (|((rdata ^ exp_beat) & bmask)) || (rresp != 2'b00);
    beat_acc = (state_q == RECV) && rvalid && rready_q;
    at_len   = (beat_q == {1'b0, len_q});
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    fail_d  = fail_q;
    proto_d = proto_q;
    err_d   = err_q;
    beat_d  = beat_q;

    case (state_q)
      IDLE: begin
        if (arvalid && arready) begin
          len_d   = arlen;
          beat_d  = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (beat_acc) begin
          beat_d = beat_q + 9'd1;
          if (beat_bad) begin
            fail_d = 1'b1;
            if (err_q != 8'hff) err_d = err_q + 8'd1;
          end
          // Burst ends on rlast or on the final expected beat; disagreement is a protocol error.
          if (rlast || at_len) begin
            state_d = DONE;
            if (rlast != at_len) begin
              proto_d = 1'b1;
              fail_d  = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase

    if (clr || !ddr_ready) begin
      state_d = IDLE;
      fail_d  = 1'b0;
      proto_d = 1'b0;
      err_d   = '0;
      beat_d  = '0;
    end

    rready_d = (state_d == RECV);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rready_q <= 1'b0;
      fail_q   <= 1'b0;
      proto_q  <= 1'b0;
      err_q    <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rready_q <= rready_d;
      fail_q   <= fail_d;
      proto_q  <= proto_d;
      err_q    <= err_d;
      beat_q   <= beat_d;
    end
  end

  assign rready    = rready_q;
  assign done      = (state_q == DONE);
  assign pass      = (state_q == DONE) && !fail_q;
  assign fail      = fail_q;
  assign proto_err = proto_q;
  assign err_cnt   = err_q;
  assign beat_cnt  = beat_q;

endmodule

// File: tb/tb_ddr_rd_data_check.sv
// Bench for ddr_rd_data_check: directed vector table, corner sequences and
// random bursts scored against a burst-level reference model.
module tb_ddr_rd_data_check;

  logic         clk = 1'b0;
  logic         rstn, ddr_ready, arvalid, arready, rlast, rvalid, rready, clr;
  logic [7:0]   arlen;
  logic [127:0] rdata, exp_data;
  logic [1:0]   rresp;
  logic [15:0]  exp_strb;
  logic         done, pass, fail, proto_err;
  logic [7:0]   err_cnt;
  logic [8:0]   beat_cnt;

  int total = 0;
  int bad   = 0;

  logic [127:0] bd [0:299];
  logic [1:0]   br [0:299];
  logic         bl [0:299];

  ddr_rd_data_check dut (
    .clk(clk), .rstn(rstn), .ddr_ready(ddr_ready), .arvalid(arvalid), .arready(arready),
    .arlen(arlen), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .exp_data(exp_data), .exp_strb(exp_strb), .clr(clr), .done(done),
    .pass(pass), .fail(fail), .proto_err(proto_err), .err_cnt(err_cnt), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    arvalid = 0; arready = 0; rvalid = 0; rlast = 0; rresp = 0; clr = 0;
    rdata = {4{$urandom}};
  endtask

  task automatic chk_clear(input string nm);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".pass"}, pass, 0);
    chk({nm, ".fail"}, fail, 0);
    chk({nm, ".proto"}, proto_err, 0);
    chk({nm, ".err"}, err_cnt, 0);
    chk({nm, ".beat"}, beat_cnt, 0);
    chk({nm, ".rready"}, rready, 0);
  endtask

  task automatic do_clr(input string nm);
    clr = 1; step(); clr = 0;
    chk_clear(nm);
  endtask

  function automatic logic [127:0] expw(input logic [127:0] ed, input int k);
    logic [127:0] e;
    e = ed;
    e[31:0] = ed[31:0] + k;
    return e;
  endfunction

  // Burst-level reference: walk beats until rlast or the final expected beat.
  function automatic void model(input int len, input logic [127:0] ed, input logic [15:0] es,
                                output int n, output int err, output bit proto);
    logic [127:0] mask;
    bit mis;
    mask = '0;
    for (int i = 0; i < 16; i++) if (es[i]) mask = mask | (128'hff << (8 * i));
    n = 0; err = 0; proto = 0;
    for (int k = 0; k < 300; k++) begin
      mis = (((bd[k] ^ expw(ed, k)) & mask) != 0) || (br[k] != 2'b00);
      if (mis && err < 255) err++;
      n = k + 1;
      if (bl[k] || k == len) begin
        proto = (bl[k] != (k == len));
        return;
      end
    end
  endfunction

  task automatic burst(input int len, input logic [127:0] ed, input logic [15:0] es,
                       input int n, input int e_err, input bit e_proto,
                       input string nm, input bit gaps);
    exp_data = ed; exp_strb = es; arlen = len[7:0];
    arvalid = 1; arready = 1; step();
    arvalid = 0; arready = 0;
    chk({nm, ".rready_on"}, rready, 1);
    for (int k = 0; k < n; k++) begin
      if (gaps) while ($urandom_range(3) == 0) begin
        rvalid = 0; rlast = $urandom_range(1); rdata = {4{$urandom}}; step();
      end
      rvalid = 1; rdata = bd[k]; rresp = br[k]; rlast = bl[k]; step();
    end
    rvalid = 0; rlast = 0; rresp = 0;
    chk({nm, ".done"}, done, 1);
    chk({nm, ".pass"}, pass, (e_err == 0 && !e_proto));
    chk({nm, ".fail"}, fail, !(e_err == 0 && !e_proto));
    chk({nm, ".proto"}, proto_err, e_proto);
    chk({nm, ".err"}, err_cnt, e_err);
    chk({nm, ".beat"}, beat_cnt, n);
    chk({nm, ".rready_off"}, rready, 0);
  endtask

  typedef struct {
    int           len;
    logic [127:0] ed;
    logic [15:0]  es;
    int           nb;
    int           last_at;
    int           bad_beat;
    int           bad_byte;
    int           resp_beat;
    int           e_beats;
    int           e_err;
    bit           e_proto;
  } vec_t;

  vec_t tbl [0:8];

  initial begin
    logic [127:0] ed, ed5678, edw;
    int n, e;
    bit p;

    ed     = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    ed5678 = {96'hdeadbeef_00000000_11112222, 32'h0000_5678};
    edw    = {96'h0, 32'hffff_fffe};
    tbl[0] = '{0, ed5678, 16'h0003, 1,  0, -1, 0,  -1, 1, 0, 0};
    tbl[1] = '{3, ed,     16'hffff, 4,  3,  2, 0,  -1, 4, 1, 0};
    tbl[2] = '{3, ed,     16'hffff, 2,  1, -1, 0,  -1, 2, 0, 1};
    tbl[3] = '{0, ed5678, 16'h0003, 1,  0,  0, 5,   0, 1, 1, 0};
    tbl[4] = '{0, ed5678, 16'h0003, 1,  0,  0, 5,  -1, 1, 0, 0};
    tbl[5] = '{2, ed,     16'hffff, 3, -1, -1, 0,  -1, 3, 0, 1};
    tbl[6] = '{3, edw,    16'hffff, 4,  3, -1, 0,  -1, 4, 0, 0};
    tbl[7] = '{1, ed,     16'h0000, 2,  1,  0, 7,  -1, 2, 0, 0};
    tbl[8] = '{5, ed,     16'hf000, 6,  5,  4, 14, -1, 6, 1, 0};

    rstn = 0; ddr_ready = 1; arlen = 0; exp_data = 0; exp_strb = 0;
    idle_in();
    #1;
    chk_clear("reset");
    step(); step();
    rstn = 1;
    step();
    chk_clear("post_reset");

    // rvalid in IDLE is neither counted nor compared
    rvalid = 1; rlast = 1; step(); step();
    chk("idle_rvalid.beat", beat_cnt, 0);
    chk("idle_rvalid.done", done, 0);
    rvalid = 0; rlast = 0;

    foreach (tbl[v]) begin
      for (int k = 0; k < tbl[v].nb; k++) begin
        bd[k] = expw(tbl[v].ed, k);
        br[k] = (k == tbl[v].resp_beat) ? 2'b10 : 2'b00;
        bl[k] = (k == tbl[v].last_at);
        if (k == tbl[v].bad_beat) bd[k][8*tbl[v].bad_byte +: 8] = bd[k][8*tbl[v].bad_byte +: 8] ^ 8'ha5;
      end
      burst(tbl[v].len, tbl[v].ed, tbl[v].es, tbl[v].e_beats, tbl[v].e_err, tbl[v].e_proto,
            $sformatf("vec%0d", v), v[0]);
      do_clr($sformatf("vec%0d_clr", v));
    end

    // ar handshake during RECV must not reload the length
    exp_data = ed; exp_strb = 16'hffff; arlen = 1;
    arvalid = 1; arready = 1; step();
    arlen = 0; rvalid = 1; rdata = expw(ed, 0); rlast = 0; step();
    arvalid = 0; arready = 0; rdata = expw(ed, 1); rlast = 1; step();
    rvalid = 0; rlast = 0;
    chk("ar_in_recv.done", done, 1);
    chk("ar_in_recv.pass", pass, 1);
    chk("ar_in_recv.beat", beat_cnt, 2);
    // DONE holds through further handshakes
    arlen = 7; arvalid = 1; arready = 1; step(); step();
    chk("ar_in_done.done", done, 1);
    chk("ar_in_done.rready", rready, 0);
    chk("ar_in_done.beat", beat_cnt, 2);
    // clr beats a simultaneous ar handshake
    clr = 1; step(); clr = 0; arvalid = 0; arready = 0;
    chk_clear("clr_vs_ar");

    // clr beats a simultaneous beat
    arlen = 3; arvalid = 1; arready = 1; step(); arvalid = 0; arready = 0;
    rvalid = 1; rdata = ~expw(ed, 0); clr = 1; step(); clr = 0; rvalid = 0;
    chk_clear("clr_vs_beat");

    // ddr_ready abort mid-burst, then ar while ddr_ready low ignored
    arlen = 7; arvalid = 1; arready = 1; step(); arvalid = 0; arready = 0;
    rvalid = 1; rdata = ~expw(ed, 0); step();
    rdata = ~expw(ed, 1); step();
    chk("abort_pre.err", err_cnt, 2);
    chk("abort_pre.fail", fail, 1);
    ddr_ready = 0; step();
    rvalid = 0;
    chk_clear("abort");
    arvalid = 1; arready = 1; step(); arvalid = 0; arready = 0;
    chk("ar_ddr_low.rready", rready, 0);
    ddr_ready = 1; step();

    // 300 single-beat bad bursts, each re-armed by clr
    for (int j = 0; j < 300; j++) begin
      bd[0] = ~expw(ed, 0); br[0] = 0; bl[0] = 1;
      burst(0, ed, 16'hffff, 1, 1, 0, "single_bad", 0);
      do_clr("single_bad_clr");
    end

    // 256-beat all-bad burst saturates err_cnt
    for (int k = 0; k < 256; k++) begin
      bd[k] = ~expw(ed, k); br[k] = 0; bl[k] = (k == 255);
    end
    burst(255, ed, 16'hffff, 256, 255, 0, "sat", 1);
    ddr_ready = 0; step(); ddr_ready = 1;
    chk_clear("sat_abort");

    // asynchronous reset mid-burst, then a fresh burst
    arlen = 3; arvalid = 1; arready = 1; step(); arvalid = 0; arready = 0;
    rvalid = 1; rdata = ~expw(ed, 0); step(); rvalid = 0;
    rstn = 0; #1;
    chk_clear("mid_reset");
    step(); rstn = 1; step();
    bd[0] = expw(ed5678, 0); br[0] = 0; bl[0] = 1;
    burst(0, ed5678, 16'h0003, 1, 0, 0, "after_reset", 0);
    do_clr("after_reset_clr");

    // random bursts against the reference model
    for (int t = 0; t < 60; t++) begin
      int len, mode, early;
      logic [127:0] red;
      logic [15:0]  res;
      len = $urandom_range(0, 15);
      red = {$urandom, $urandom, $urandom, $urandom};
      res = $urandom;
      mode = $urandom_range(0, 3);
      early = $urandom_range(0, len);
      for (int k = 0; k < 20; k++) begin
        bd[k] = expw(red, k);
        if ($urandom_range(0, 3) == 0) bd[k][8*$urandom_range(0, 15) +: 8] = $urandom;
        br[k] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        bl[k] = (mode == 0) ? 1'b0 : (mode == 1) ? (k == early) : (k == len);
      end
      model(len, red, res, n, e, p);
      burst(len, red, res, n, e, p, $sformatf("rnd%0d", t), 1);
      do_clr("rnd_clr");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_rd_data_check.md
DDR_RD_DATA_CHECK -- requirements
Module: ddr_rd_data_check

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ddr_ready, input, 1 bit: DDR init complete; low aborts check.
REQ-004 SHALL have port arvalid, input, 1 bit: monitored read-address valid.
REQ-005 SHALL have port arready, input, 1 bit: monitored read-address ready.
REQ-006 SHALL have port arlen, input, 8 bits: monitored burst length minus one.
REQ-007 SHALL have port rdata, input, 128 bits: read data beat.
REQ-008 SHALL have port rresp, input, 2 bits: read response; 2'b00 = OKAY.
REQ-009 SHALL have port rlast, input, 1 bit: last beat of burst.
REQ-010 SHALL have port rvalid, input, 1 bit: read data valid.
REQ-011 SHALL have port rready, output, 1 bit: read data accept.
REQ-012 SHALL have port exp_data, input, 128 bits: expected beat-0 data.
REQ-013 SHALL have port exp_strb, input, 16 bits: byte compare mask; bit i covers rdata[8i+7:8i].
REQ-014 SHALL have port clr, input, 1 bit: one-cycle pulse; re-arms checker.
REQ-015 SHALL have port done, output, 1 bit: burst check complete.
REQ-016 SHALL have port pass, output, 1 bit: done with zero errors.
REQ-017 SHALL have port fail, output, 1 bit: sticky error seen.
REQ-018 SHALL have port proto_err, output, 1 bit: sticky rlast/length mismatch.
REQ-019 SHALL have port err_cnt, output, 8 bits: mismatching-beat count, saturating at 255.
REQ-020 SHALL have port beat_cnt, output, 9 bits: beats accepted in current burst.

Function
REQ-021 SHALL implement states IDLE, RECV, DONE; reset state IDLE.
REQ-022 IDLE: rready=0; on arvalid&arready with ddr_ready=1, SHALL capture arlen into len_q, clear beat_cnt, go RECV next cycle.
REQ-023 RECV: rready SHALL be 1 registered (asserted the cycle after entry); beat accepted only when rvalid&rready.
REQ-024 Expected data for beat k SHALL equal exp_data with bits [31:0] replaced by exp_data[31:0]+k modulo 2^32; bits [127:32] unchanged.
REQ-025 Beat mismatch SHALL be any byte i with exp_strb[i]=1 and differing data, or rresp!=2'b00; bytes with exp_strb[i]=0 ignored.
REQ-026 On mismatching beat, err_cnt SHALL increment by 1 (hold at 255) and fail SHALL set in the same edge.
REQ-027 Each accepted beat SHALL increment beat_cnt by 1.
REQ-028 Accepted beat with rlast=1 and beat_cnt==len_q: SHALL go DONE, no protocol error.
REQ-029 Accepted beat with rlast=1 and beat_cnt<len_q, or rlast=0 and beat_cnt==len_q: SHALL set proto_err and fail, go DONE.
REQ-030 DONE: rready=0, done=1, pass=~fail; SHALL hold until clr or ddr_ready low; further ar handshakes ignored.
REQ-031 ar handshakes while in RECV SHALL be ignored (one burst outstanding).
REQ-032 clr SHALL from any state return to IDLE and clear done, fail, proto_err, err_cnt, beat_cnt; clr wins over a simultaneous beat or ar handshake.
REQ-033 ddr_ready low SHALL synchronously force IDLE with same clearing as clr, taking priority over clr and all handshakes.
REQ-034 rvalid while rready=0 SHALL not be counted or compared.

Reset
REQ-035 rstn low SHALL asynchronously force IDLE, rready=0, done=0, pass=0, fail=0, proto_err=0, err_cnt=0, beat_cnt=0, len_q=0.
REQ-036 Reset asserted mid-burst SHALL discard the burst; first ar handshake after release starts a fresh check.

Verification
REQ-037 arlen=0, exp_data=...00005678, exp_strb=16'h0003, one beat rdata=...00005678 rlast=1 rresp=0 -> done=1, pass=1, err_cnt=0, beat_cnt=1.
REQ-038 arlen=3, beats with low word exp+0..exp+3, beat 2 byte 0 corrupted, rlast on beat 3 -> done=1, fail=1, err_cnt=1, proto_err=0, beat_cnt=4.
REQ-039 arlen=3, rlast on beat 1 -> proto_err=1, fail=1, done=1, beat_cnt=2; following clr -> all flags 0, state IDLE.
REQ-040 exp_strb=16'h0003, rdata differs only in byte 5, rresp=2'b10 -> err_cnt=1 (from rresp only); repeat with rresp=0 -> pass=1.
REQ-041 ddr_ready dropped during RECV, then 300 single-beat bad bursts each cleared only by reset-free re-arm -> abort clears flags; without clr across a 256-beat burst of all-bad data err_cnt saturates at 255.
